// File: rtl/access_sequencer_if.sv
// Signal bundle between the access sequencer and its keypad/sensor/actuator environment.
// The master side drives the sensor and keypad inputs; the slave side is the controller.
interface access_sequencer_if;
  logic       presence;
  logic       key_valid;
  logic [3:0] key_code;
  logic       reed;
  logic       servo_open;
  logic       buzz;
  logic [2:0] state_code;
  logic       profile_id;
  logic       granted;
  logic       denied;

  modport master (
    output presence, key_valid, key_code, reed,
    input  servo_open, buzz, state_code, profile_id, granted, denied
  );

  modport slave (
    input  presence, key_valid, key_code, reed,
    output servo_open, buzz, state_code, profile_id, granted, denied
  );
endinterface

// File: rtl/access_sequencer.sv
// Door-access controller: presence -> profile select -> PIN entry -> servo unlock ->
// door monitoring, with failed-attempt lockout and forced-entry / door-ajar alarm.
module access_sequencer #(
  parameter int unsigned PIN_LEN       = 4,
  parameter logic [15:0] PIN0          = 16'h4693,
  parameter logic [15:0] PIN1          = 16'h1234,
  parameter logic [2:0]  MAX_FAILS     = 3'd3,
  parameter logic [31:0] ENTRY_TIMEOUT = 32'd250_000_000,
  parameter logic [31:0] UNLOCK_TIME   = 32'd250_000_000,
  parameter logic [31:0] AJAR_TIME     = 32'd1_500_000_000,
  parameter logic [31:0] LOCKOUT_TIME  = 32'd1_500_000_000
) (
  input  logic              clk,
  input  logic              reset,
  access_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROFILE = 3'd1,
    S_PIN     = 3'd2,
    S_UNLOCK  = 3'd3,
    S_OPEN    = 3'd4,
    S_ALARM   = 3'd5
  } state_e;

  localparam logic [3:0] K_A    = 4'hA;
  localparam logic [3:0] K_B    = 4'hB;
  localparam logic [3:0] K_STAR = 4'hE;
  localparam logic [3:0] K_HASH = 4'hF;
  localparam logic [2:0] PIN_LEN_C = 3'(PIN_LEN);

  // Only the low PIN_LEN digits of the buffer take part in the comparison.
  function automatic logic [15:0] pin_mask(input int unsigned len);
    logic [15:0] m;
    case (len)
      32'd1:   m = 16'h000F;
      32'd2:   m = 16'h00FF;
      32'd3:   m = 16'h0FFF;
      default: m = 16'hFFFF;
    endcase
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        sel_q, sel_d;
  logic        pid_q, pid_d;
  logic [15:0] pin_buf_q, pin_buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  fail_q, fail_d;
  logic        reed_s1_q, reed_s2_q;
  logic        servo_q, servo_d;
  logic        buzz_q, buzz_d;
  logic        granted_q, granted_d;
  logic        denied_q, denied_d;

  logic        reed_s;
  logic        key_is_digit;
  logic        key_clr;
  logic        pin_match;
  logic [15:0] pin_sel;
  logic [31:0] timer_inc;

  assign reed_s       = reed_s2_q;
  assign key_is_digit = (bus.key_code <= 4'd9);
  assign pin_sel      = pid_q ? PIN1 : PIN0;
  assign pin_match    = (cnt_q == PIN_LEN_C) && !ovf_q &&
                        (((pin_buf_q ^ pin_sel) & pin_mask(PIN_LEN)) == 16'h0000);
  assign timer_inc    = (timer_q == 32'hFFFF_FFFF) ? timer_q : (timer_q + 32'd1);

  // State, datapath, reed synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= 32'd0;
      sel_q     <= 1'b0;
      pid_q     <= 1'b0;
      pin_buf_q <= 16'h0000;
      cnt_q     <= 3'd0;
      ovf_q     <= 1'b0;
      fail_q    <= 3'd0;
      reed_s1_q <= 1'b1;
      reed_s2_q <= 1'b1;
      servo_q   <= 1'b0;
      buzz_q    <= 1'b0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      pid_q     <= pid_d;
      pin_buf_q <= pin_buf_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      fail_q    <= fail_d;
      reed_s1_q <= bus.reed;
      reed_s2_q <= reed_s1_q;
      servo_q   <= servo_d;
      buzz_q    <= buzz_d;
      granted_q <= granted_d;
      denied_q  <= denied_d;
    end
  end

  // Next-state, entry datapath and output decode.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pid_d     = pid_q;
    pin_buf_d = pin_buf_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    fail_d    = fail_q;
    granted_d = 1'b0;
    denied_d  = 1'b0;
    key_clr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!reed_s) begin
          state_d = S_ALARM;
        end else if (bus.presence) begin
          state_d = S_PROFILE;
          sel_d   = 1'b0;
          pid_d   = 1'b0;
        end else begin
        end
      end

      S_PROFILE: begin
        if (!reed_s) begin
          state_d = S_ALARM;
        end else if (bus.key_valid) begin
          key_clr = 1'b1;
          case (bus.key_code)
            K_A: begin
              sel_d = 1'b1;
              pid_d = 1'b0;
            end
            K_B: begin
              sel_d = 1'b1;
              pid_d = 1'b1;
            end
            K_HASH: begin
              sel_d = 1'b0;
              pid_d = 1'b0;
            end
            K_STAR: begin
              if (sel_q) begin
                state_d   = S_PIN;
                pin_buf_d = 16'h0000;
                cnt_d     = 3'd0;
                ovf_d     = 1'b0;
              end else begin
              end
            end
            default: begin
            end
          endcase
        end else if (timer_q >= ENTRY_TIMEOUT) begin
          state_d = S_IDLE;
          sel_d   = 1'b0;
          pid_d   = 1'b0;
        end else begin
        end
      end

      S_PIN: begin
        if (!reed_s) begin
          state_d = S_ALARM;
        end else if (bus.key_valid) begin
          key_clr = 1'b1;
          if (key_is_digit) begin
            if (cnt_q < PIN_LEN_C) begin
              pin_buf_d = {pin_buf_q[11:0], bus.key_code};
              cnt_d     = cnt_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (bus.key_code == K_STAR) begin
            pin_buf_d = 16'h0000;
            cnt_d     = 3'd0;
            ovf_d     = 1'b0;
          end else if (bus.key_code == K_HASH) begin
            pin_buf_d = 16'h0000;
            cnt_d     = 3'd0;
            ovf_d     = 1'b0;
            if (pin_match) begin
              granted_d = 1'b1;
              fail_d    = 3'd0;
              state_d   = S_UNLOCK;
            end else begin
              denied_d = 1'b1;
              fail_d   = fail_q + 3'd1;
              if ((fail_q + 3'd1) == MAX_FAILS) begin
                state_d = S_ALARM;
              end else begin
                state_d = S_PIN;
              end
            end
          end else begin
          end
        end else if (timer_q >= ENTRY_TIMEOUT) begin
          state_d   = S_IDLE;
          sel_d     = 1'b0;
          pid_d     = 1'b0;
          pin_buf_d = 16'h0000;
          cnt_d     = 3'd0;
          ovf_d     = 1'b0;
        end else begin
        end
      end

      S_UNLOCK: begin
        if (!reed_s) begin
          state_d = S_OPEN;
        end else if (timer_q >= UNLOCK_TIME) begin
          state_d = S_IDLE;
        end else begin
        end
      end

      S_OPEN: begin
        if (reed_s) begin
          state_d = S_IDLE;
        end else begin
        end
      end

      S_ALARM: begin
        if ((timer_q >= LOCKOUT_TIME) && reed_s) begin
          state_d = S_IDLE;
          fail_d  = 3'd0;
        end else begin
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any key in an entry state counts as activity and restarts the idle timer.
    if ((state_d != state_q) || key_clr) begin
      timer_d = 32'd0;
    end else begin
      timer_d = timer_inc;
    end

    servo_d = (state_d == S_UNLOCK) || (state_d == S_OPEN);

    // Ajar buzz latches until the door closes; the saturating timer keeps it asserted.
    if (state_d == S_ALARM) begin
      buzz_d = 1'b1;
    end else if ((state_q == S_OPEN) && (state_d == S_OPEN)) begin
      buzz_d = buzz_q || (timer_q >= AJAR_TIME);
    end else begin
      buzz_d = 1'b0;
    end
  end

  assign bus.state_code = state_q;
  assign bus.profile_id = pid_q;
  assign bus.servo_open = servo_q;
  assign bus.buzz       = buzz_q;
  assign bus.granted    = granted_q;
  assign bus.denied     = denied_q;

endmodule

// File: tb/tb_access_sequencer.sv
// Self-checking bench for access_sequencer: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model of the controller.
module tb_access_sequencer;

  localparam int          PIN_LEN = 4;
  localparam logic [15:0] PIN0    = 16'h4693;
  localparam logic [15:0] PIN1    = 16'h1234;
  localparam int          MAXF    = 3;
  localparam int          ET      = 100;
  localparam int          UT      = 50;
  localparam int          AT      = 60;
  localparam int          LT      = 80;

  logic clk;
  logic reset;
  access_sequencer_if bus();

  access_sequencer #(
    .PIN_LEN      (PIN_LEN),
    .PIN0         (PIN0),
    .PIN1         (PIN1),
    .MAX_FAILS    (3'd3),
    .ENTRY_TIMEOUT(32'd100),
    .UNLOCK_TIME  (32'd50),
    .AJAR_TIME    (32'd60),
    .LOCKOUT_TIME (32'd80)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (codes: 0 idle, 1 profile, 2 pin, 3 unlock, 4 open, 5 alarm)
  int     m_st, m_fail, m_pid;
  longint m_timer;
  bit     m_sel, m_ovf, m_r1, m_r2;
  int     m_digits[$];
  bit     m_servo, m_buzz, m_gr, m_dn;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit model_match();
    int pin;
    pin = m_pid ? int'(PIN1) : int'(PIN0);
    if (m_digits.size() != PIN_LEN || m_ovf) return 1'b0;
    for (int k = 0; k < PIN_LEN; k++)
      if (m_digits[k] != ((pin >> (4 * (PIN_LEN - 1 - k))) & 15)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int  ns, k;
    bit  rs, kv, kclr;
    if (reset) begin
      m_st = 0; m_fail = 0; m_pid = 0; m_timer = 0; m_sel = 0; m_ovf = 0;
      m_r1 = 1; m_r2 = 1; m_digits.delete();
      m_servo = 0; m_buzz = 0; m_gr = 0; m_dn = 0;
      return;
    end
    rs = m_r2; m_r2 = m_r1; m_r1 = bus.reed;
    kv = bus.key_valid; k = int'(bus.key_code);
    ns = m_st; kclr = 0; m_gr = 0; m_dn = 0;
    case (m_st)
      0: if (!rs) ns = 5; else if (bus.presence) begin ns = 1; m_sel = 0; m_pid = 0; end
      1: if (!rs) ns = 5;
         else if (kv) begin
           kclr = 1;
           if (k == 10) begin m_sel = 1; m_pid = 0; end
           else if (k == 11) begin m_sel = 1; m_pid = 1; end
           else if (k == 15) begin m_sel = 0; m_pid = 0; end
           else if (k == 14 && m_sel) begin ns = 2; m_digits.delete(); m_ovf = 0; end
         end else if (m_timer >= ET) begin ns = 0; m_sel = 0; m_pid = 0; end
      2: if (!rs) ns = 5;
         else if (kv) begin
           kclr = 1;
           if (k <= 9) begin
             if (m_digits.size() < PIN_LEN) m_digits.push_back(k); else m_ovf = 1;
           end else if (k == 14) begin
             m_digits.delete(); m_ovf = 0;
           end else if (k == 15) begin
             if (model_match()) begin m_gr = 1; m_fail = 0; ns = 3; end
             else begin m_dn = 1; m_fail++; if (m_fail == MAXF) ns = 5; end
             m_digits.delete(); m_ovf = 0;
           end
         end else if (m_timer >= ET) begin
           ns = 0; m_sel = 0; m_pid = 0; m_digits.delete(); m_ovf = 0;
         end
      3: if (!rs) ns = 4; else if (m_timer >= UT) ns = 0;
      4: if (rs) ns = 0;
      5: if (m_timer >= LT && rs) begin ns = 0; m_fail = 0; end
      default: ns = 0;
    endcase
    m_buzz  = (ns == 5) || (m_st == 4 && ns == 4 && (m_buzz || m_timer >= AT));
    m_servo = (ns == 3) || (ns == 4);
    m_timer = (ns != m_st || kclr) ? 0 : m_timer + 1;
    m_st    = ns;
  endtask

  task automatic check_all();
    check_val("state_code", 32'(bus.state_code), 32'(m_st));
    check_val("servo_open", 32'(bus.servo_open), 32'(m_servo));
    check_val("buzz",       32'(bus.buzz),       32'(m_buzz));
    check_val("profile_id", 32'(bus.profile_id), 32'(m_pid));
    check_val("granted",    32'(bus.granted),    32'(m_gr));
    check_val("denied",     32'(bus.denied),     32'(m_dn));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic key(input int k);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(k);
    cycle();
    bus.key_valid = 1'b0;
  endtask

  task automatic press(input int k);
    key(k);
    cycle();
  endtask

  task automatic enter_digits(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) press(int'((p >> (4 * i)) & 16'h000F));
  endtask

  task automatic start_profile(input int letter);
    bus.presence = 1'b1;
    cycle();
    bus.presence = 1'b0;
    press(letter);
    press(14);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int pool[10] = '{4, 6, 9, 3, 1, 2, 10, 11, 14, 15};

  initial begin
    reset = 1'b1;
    bus.presence = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.reed = 1'b1;
    cycle();
    check_val("rst_state", 32'(bus.state_code), 32'd0);
    check_val("rst_servo", 32'(bus.servo_open), 32'd0);
    reset = 1'b0;
    cycle();

    // Happy path, profile A
    bus.presence = 1'b1;
    cycle();
    check_val("happy_profile", 32'(bus.state_code), 32'd1);
    bus.presence = 1'b0;
    press(10); press(14);
    check_val("happy_pin", 32'(bus.state_code), 32'd2);
    press(4); press(6); press(9); press(3);
    key(15);
    check_val("happy_granted", 32'(bus.granted), 32'd1);
    check_val("happy_unlock", 32'(bus.state_code), 32'd3);
    check_val("happy_servo", 32'(bus.servo_open), 32'd1);
    cycle();
    check_val("happy_granted_pulse", 32'(bus.granted), 32'd0);
    bus.reed = 1'b0;
    wait_cycles(3);
    check_val("happy_open", 32'(bus.state_code), 32'd4);
    bus.reed = 1'b1;
    wait_cycles(3);
    check_val("happy_closed", 32'(bus.state_code), 32'd0);
    check_val("happy_relatch", 32'(bus.servo_open), 32'd0);

    // Profile B: wrong then right PIN, then unlock timeout
    start_profile(11);
    check_val("b_profile_id", 32'(bus.profile_id), 32'd1);
    enter_digits(16'h4693);
    key(15);
    check_val("b_denied", 32'(bus.denied), 32'd1);
    check_val("b_stay_pin", 32'(bus.state_code), 32'd2);
    cycle();
    enter_digits(16'h1234);
    key(15);
    check_val("b_granted", 32'(bus.granted), 32'd1);
    wait_cycles(55);
    check_val("unlock_timeout", 32'(bus.state_code), 32'd0);
    check_val("unlock_timeout_servo", 32'(bus.servo_open), 32'd0);

    // Overflow then clear, then door ajar
    start_profile(11);
    enter_digits(16'h1234); press(5);
    key(15);
    check_val("ovf_denied", 32'(bus.denied), 32'd1);
    cycle();
    press(1); press(14);
    enter_digits(16'h1234);
    key(15);
    check_val("clear_granted", 32'(bus.granted), 32'd1);
    bus.reed = 1'b0;
    wait_cycles(3 + 65);
    check_val("ajar_buzz", 32'(bus.buzz), 32'd1);
    bus.reed = 1'b1;
    wait_cycles(3);
    check_val("ajar_close_state", 32'(bus.state_code), 32'd0);
    check_val("ajar_close_buzz", 32'(bus.buzz), 32'd0);

    // Lockout after three wrong PINs, held by open door
    start_profile(10);
    for (int a = 0; a < 3; a++) begin
      enter_digits(16'h1111);
      key(15);
      if (a < 2) cycle();
    end
    check_val("lock_state", 32'(bus.state_code), 32'd5);
    check_val("lock_buzz", 32'(bus.buzz), 32'd1);
    cycle();
    press(4); press(15);
    bus.reed = 1'b0;
    wait_cycles(100);
    check_val("lock_reed_hold", 32'(bus.state_code), 32'd5);
    bus.reed = 1'b1;
    wait_cycles(5);
    check_val("lock_exit", 32'(bus.state_code), 32'd0);

    // PIN entry timeout, with a key at cycle 99 restarting it
    start_profile(11);
    wait_cycles(97);
    key(1);
    check_val("pin_key99_holds", 32'(bus.state_code), 32'd2);
    wait_cycles(102);
    check_val("pin_timeout", 32'(bus.state_code), 32'd0);

    // Forced entry from idle
    bus.reed = 1'b0;
    wait_cycles(3);
    check_val("forced_alarm", 32'(bus.state_code), 32'd5);
    bus.reed = 1'b1;
    wait_cycles(90);
    check_val("forced_exit", 32'(bus.state_code), 32'd0);

    // Reset while open and buzzing
    start_profile(11);
    enter_digits(16'h1234);
    key(15);
    bus.reed = 1'b0;
    wait_cycles(3 + 65);
    check_val("pre_reset_buzz", 32'(bus.buzz), 32'd1);
    reset = 1'b1;
    bus.reed = 1'b1;
    cycle();
    check_val("reset_state", 32'(bus.state_code), 32'd0);
    check_val("reset_servo", 32'(bus.servo_open), 32'd0);
    check_val("reset_buzz", 32'(bus.buzz), 32'd0);
    check_val("reset_pid", 32'(bus.profile_id), 32'd0);
    reset = 1'b0;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.presence  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) bus.reed = ~bus.reed;
      bus.key_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) bus.key_code = 4'($urandom_range(0, 15));
      else bus.key_code = 4'(pool[$urandom_range(0, 9)]);
      cycle();
    end
    bus.key_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/access_sequencer.md
Name: access_sequencer

Overview:
- Central door-access controller. It sequences presence detection, profile selection, PIN entry, servo unlock, door monitoring and alarm.
- Consumes decoded keypad events, the presence flag derived from the ultrasonic range, and the reed switch.
- Drives the servo position select, the buzzer, and a state code for the LCD driver.
- Supports two user profiles with separate PINs, a failed-attempt lockout, and forced-entry/door-ajar alarms.

Parameters:
- PIN_LEN, 4, number of digits per PIN (1..4).
- PIN0, 16'h4693, BCD PIN for profile A; most-significant digit is entered first.
- PIN1, 16'h1234, BCD PIN for profile B.
- MAX_FAILS, 3, number of consecutive wrong PINs that triggers lockout (1..7).
- ENTRY_TIMEOUT, 250_000_000, idle cycles allowed in PROFILE/PIN before abort.
- UNLOCK_TIME, 250_000_000, cycles the servo stays open waiting for the door to open.
- AJAR_TIME, 1_500_000_000, cycles the door may stay open before the buzzer sounds.
- LOCKOUT_TIME, 1_500_000_000, minimum alarm duration in cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- presence  in  1  level; 1 = object within range.
- key_valid  in  1  single-cycle strobe: key_code is valid.
- key_code  in  4  0-9 = digits, A-D = letters, E = '*', F = '#'.
- reed  in  1  asynchronous input; 1 = door closed, 0 = door open.
- servo_open  out  1  1 = latch released.
- buzz  out  1  buzzer enable.
- state_code  out  3  IDLE=0, PROFILE=1, PIN=2, UNLOCK=3, OPEN=4, ALARM=5.
- profile_id  out  1  selected profile (0 = A, 1 = B).
- granted  out  1  one-cycle pulse on correct PIN.
- denied  out  1  one-cycle pulse on rejected PIN.

Behaviour:
- Reset values: state IDLE; all outputs 0; fail_cnt 0; PIN buffer and digit count 0; timer 0; reed synchronizer flops set to 1.
- reed passes through a 2-flop synchronizer (reed_s), so reed edges act 2 cycles late.
- All outputs are registered and change 1 cycle after the sampling edge of the causing input.
- servo_open=1 only in UNLOCK/OPEN. buzz=1 in ALARM, and in OPEN once ajar.
- Timer: one 32-bit counter. It clears on every state change and on every key_valid accepted in PROFILE/PIN; otherwise it increments, saturating.
- IDLE: presence=1 -> PROFILE. reed_s=0 -> ALARM (forced entry; this has priority over presence).
- PROFILE:
  - 'A' sets profile_id=0 and marks the profile selected; 'B' sets profile_id=1 and marks it selected.
  - '#' clears the selection.
  - '*' with a selection made -> PIN. '*' without a selection is ignored.
  - Digits, 'C' and 'D' are ignored.
- PIN:
  - A digit shifts into the buffer (buf = {buf[11:0], d}) while count < PIN_LEN; count increments.
  - A digit arriving with count == PIN_LEN sets an overflow flag and does not change the buffer.
  - '*' clears buffer, count and overflow.
  - Letters are ignored.
  - '#' submits. The PIN matches iff count==PIN_LEN, no overflow, and the low PIN_LEN digits of buf equal the low PIN_LEN digits of the selected PIN.
  - Match: granted pulse, fail_cnt=0, -> UNLOCK.
  - Mismatch: denied pulse, fail_cnt+1; if the new value equals MAX_FAILS -> ALARM, else stay in PIN with buffer/count/overflow cleared.
- Timeout: timer reaching ENTRY_TIMEOUT in PROFILE/PIN -> IDLE. The selection and buffer clear; fail_cnt is retained.
- PROFILE/PIN: reed_s=0 -> ALARM, with priority over key events. presence dropping does not abort entry.
- Simultaneous events: key_valid in the same cycle as the timeout is processed and the timeout is suppressed.
- UNLOCK: reed_s=0 -> OPEN. Timer reaching UNLOCK_TIME with the door still closed -> IDLE (relock). Keys are ignored.
- OPEN: reed_s=1 -> IDLE. Timer reaching AJAR_TIME sets buzz=1, which holds until exit. Keys are ignored.
- ALARM: buzz=1, servo_open=0, keys ignored. Exits to IDLE only when timer >= LOCKOUT_TIME and reed_s=1; fail_cnt clears on exit.
- Reset mid-operation returns immediately to the reset values, including dropping servo_open and buzz.

Test Plan (bench params: ENTRY_TIMEOUT=100, UNLOCK_TIME=50, AJAR_TIME=60, LOCKOUT_TIME=80, defaults otherwise):
- Happy path:
  - Stimulus: presence=1, keys A,*,4,6,9,3,#.
  - Response: state 0->1->2; granted pulses exactly 1 cycle, state_code=3, servo_open=1.
  - Then reed=0 -> state 4 after 3 cycles; reed=1 -> state 0 and servo_open=0.
- Profile B:
  - Stimulus: B,*,4,6,9,3,# gives denied=1 and state stays 2; then 1,2,3,4,# gives granted.
  - Overflow: 1,2,3,4,5,# gives denied.
  - Clear: 1,*,1,2,3,4,# gives granted.
- Lockout:
  - Stimulus: three wrong PINs.
  - Response: after the third '#', state 5 and buzz=1; keys ignored.
  - Exit: state 0 at timer 80 with reed=1. If reed=0, it stays in 5 until reed returns to 1.
- Timeouts:
  - No keys for 100 cycles in PIN -> IDLE. A key at cycle 99 restarts the count.
  - UNLOCK with the door never opened -> IDLE after 50 cycles, servo_open=0.
- Forced entry/ajar:
  - reed=0 in IDLE -> ALARM.
  - Door held open 60 cycles in OPEN -> buzz=1; closing it -> IDLE, buzz=0.
- Reset mid-operation: assert reset while in OPEN with buzz=1 -> next cycle all outputs 0, state 0.
